// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rr_select.sv
// Round-robin selector: one-hot pick of the first requester strictly after
// last_owner, wrapping around. Zero output when nobody requests.
module rr_select
    import uart_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic [NUM_REQ-1:0] grant
);

    logic             found;
    logic [IDX_W-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IDX_W'((int'(last_owner) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates several packet byte streams onto one UART transmitter; the grant
// is held for a whole packet unless the owner stalls for MAX_GAP cycles.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int MAX_GAP = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*BYTE_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx_start,
    output logic [BYTE_W-1:0]         tx_data,
    input  logic                      tx_done,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      gap_timeout,
    output state_t                    state_dbg
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GAP_W = $clog2(MAX_GAP + 1);
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(MAX_GAP - 1);

    state_t             state;
    state_t             state_nxt;
    logic [NUM_REQ-1:0] grant_rr;
    logic [IDX_W-1:0]   last_owner;
    logic [IDX_W-1:0]   owner_idx;
    logic [BYTE_W-1:0]  owner_data;
    logic               owner_last;
    logic               owner_valid;
    logic               last_q;
    logic [GAP_W-1:0]   gap_cnt;
    logic               take;
    logic               accept;
    logic               timeout;
    logic               release_pkt;

    assign state_dbg = state;

    rr_select #(
        .NUM_REQ(NUM_REQ)
    ) u_rr_select (
        .req       (req_valid),
        .last_owner(last_owner),
        .grant     (grant_rr)
    );

    // Handshake: a byte transfers in a SEND cycle where the owner's req_valid is
    // high; data and last are captured on that edge and req_ready pulses the
    // following cycle, so requesters hold data/last until they see req_ready.
    always_comb begin
        owner_idx  = '0;
        owner_data = '0;
        owner_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                owner_idx  = IDX_W'(i);
                owner_data = req_data[i*BYTE_W +: BYTE_W];
                owner_last = req_last[i];
            end
        end
    end

    assign owner_valid = |(req_valid & grant);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (take) state_nxt = SEND;
            end
            SEND: begin
                if (accept)       state_nxt = WAIT_DONE;
                else if (timeout) state_nxt = IDLE;
            end
            WAIT_DONE: begin
                if (tx_done) state_nxt = last_q ? IDLE : SEND;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        take        = 1'b0;
        accept      = 1'b0;
        timeout     = 1'b0;
        release_pkt = 1'b0;
        case (state)
            IDLE: begin
                take = |req_valid;
            end
            SEND: begin
                accept      = owner_valid;
                timeout     = !owner_valid && (gap_cnt == GAP_LIMIT);
                release_pkt = timeout;
            end
            WAIT_DONE: begin
                release_pkt = tx_done && last_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant       <= '0;
            last_owner  <= IDX_W'(NUM_REQ - 1);
            gap_cnt     <= '0;
            tx_data     <= '0;
            last_q      <= 1'b0;
            req_ready   <= '0;
            tx_start    <= 1'b0;
            gap_timeout <= 1'b0;
        end else begin
            req_ready   <= accept ? grant : '0;
            tx_start    <= accept;
            gap_timeout <= timeout;
            if (accept) begin
                tx_data <= owner_data;
                last_q  <= owner_last;
            end
            if (take) begin
                grant <= grant_rr;
            end else if (release_pkt) begin
                grant      <= '0;
                last_owner <= owner_idx;
            end
            // Counts stalled SEND cycles only; any other cycle restarts it.
            if (state == SEND && !owner_valid && !timeout) begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end else begin
                gap_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester packet queues feed the DUT, and a
// packet-level round-robin model predicts the (owner, byte) order on tx.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int MAX_GAP = 16;

    logic                 clk;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_done;
    logic [NUM_REQ-1:0]   grant;
    logic                 gap_timeout;
    state_t               state_dbg;

    uart_tx_arbiter #(
        .NUM_REQ(NUM_REQ),
        .MAX_GAP(MAX_GAP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_done    (tx_done),
        .grant      (grant),
        .gap_timeout(gap_timeout),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int         checks;
    int         errors;
    int         cycle;
    logic [8:0] src_q [NUM_REQ][$];
    logic [8:0] pend_q[NUM_REQ][$];
    logic [9:0] exp_q[$];
    int         gap_left[NUM_REQ];
    int         model_lo;
    bit         tx_busy;
    int         tx_cnt;
    logic [7:0] tx_hold;
    int         last_done_cycle;
    int         timeout_seen;
    int         n_tx_start;
    int         first_start_cycle;
    bit         spurious_done;
    bit         grant_fix_en;
    logic [3:0] grant_fix;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    // Reference: whole packets, served round-robin after the previous owner.
    task automatic run_model();
        int         pick;
        logic [8:0] b;
        while (1) begin
            pick = -1;
            for (int k = 1; k <= NUM_REQ; k++) begin
                int idx;
                idx = (model_lo + k) % NUM_REQ;
                if (pick < 0 && pend_q[idx].size() > 0) pick = idx;
            end
            if (pick < 0) break;
            do begin
                b = pend_q[pick].pop_front();
                exp_q.push_back({2'(pick), b[7:0]});
            end while (!b[8]);
            model_lo = pick;
        end
    endtask

    task automatic load_byte(input int r, input logic [7:0] d, input logic last, input bit to_model);
        src_q[r].push_back({last, d});
        if (to_model) pend_q[r].push_back({last, d});
    endtask

    task automatic load_packet(input int r, input int len);
        for (int j = 0; j < len; j++) begin
            load_byte(r, 8'($urandom), (j == len - 1), 1'b1);
        end
    endtask

    // One cycle: observe DUT at negedge, then drive requesters and transmitter.
    task automatic step();
        logic [9:0] e;
        logic [8:0] f;
        @(negedge clk);
        cycle++;
        if (tx_start) begin
            n_tx_start++;
            if (first_start_cycle < 0) first_start_cycle = cycle;
            check("exp_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("tx_data", tx_data, e[7:0]);
                check("tx_grant", grant, 32'(1) << e[9:8]);
            end
            tx_busy = 1'b1;
            tx_hold = tx_data;
            tx_cnt  = $urandom_range(2, 6);
        end
        if (req_ready != '0 || tx_start) begin
            check("ready_onehot", $onehot(req_ready), 1);
            check("ready_owner", req_ready & ~grant, 0);
            check("ready_with_start", |req_ready, tx_start);
        end
        if (gap_timeout) begin
            timeout_seen++;
            check("gap_latency", cycle - last_done_cycle, MAX_GAP + 1);
            check("grant_after_timeout", grant, 0);
        end
        if (grant_fix_en && grant != '0) check("grant_hold", grant, grant_fix);

        tx_done = 1'b0;
        if (tx_busy && !tx_start) begin
            tx_cnt--;
            if (tx_cnt == 0) begin
                check("tx_data_stable", tx_data, tx_hold);
                tx_done         = 1'b1;
                tx_busy         = 1'b0;
                last_done_cycle = cycle;
            end
        end
        if (spurious_done) begin
            tx_done       = 1'b1;
            spurious_done = 1'b0;
        end

        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                if (src_q[i].size() > 0) begin
                    f = src_q[i].pop_front();
                    if (!f[8]) gap_left[i] = $urandom_range(0, 4);
                end
            end else if (gap_left[i] > 0) begin
                gap_left[i]--;
            end
            if (src_q[i].size() > 0 && gap_left[i] == 0) begin
                f = src_q[i][0];
                req_valid[i]       = 1'b1;
                req_data[i*8 +: 8] = f[7:0];
                req_last[i]        = f[8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[i*8 +: 8] = 8'($urandom);
                req_last[i]        = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || tx_busy) && n < budget) begin
            step();
            n++;
        end
        check("drain", exp_q.size() + (tx_busy ? 1 : 0), 0);
        repeat (3) step();
    endtask

    task automatic wait_grant(input logic [3:0] mask, input int budget);
        int n;
        n = 0;
        while (grant != mask && n < budget) begin
            step();
            n++;
        end
        check("wait_grant", grant, mask);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            src_q[i].delete();
            pend_q[i].delete();
            gap_left[i] = 0;
        end
        exp_q.delete();
        tx_busy       = 1'b0;
        spurious_done = 1'b0;
        repeat (3) step();
        check("rst_grant", grant, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_gap_timeout", gap_timeout, 0);
        check("rst_state", state_dbg, IDLE);
        rst_n    = 1'b1;
        model_lo = NUM_REQ - 1;
        step();
    endtask

    initial begin
        int s;
        int n;
        int raise_cycle;
        checks = 0; errors = 0; cycle = 0; n_tx_start = 0;
        req_valid = '0; req_data = '0; req_last = '0; tx_done = 1'b0;
        rst_n = 1'b0; tx_busy = 1'b0; spurious_done = 1'b0;
        grant_fix_en = 1'b0; grant_fix = '0; timeout_seen = 0;
        last_done_cycle = 0; first_start_cycle = -1;
        for (int i = 0; i < NUM_REQ; i++) gap_left[i] = 0;

        do_reset();

        // single requester, two-byte packet, with first-byte latency
        load_byte(2, 8'h41, 1'b0, 1'b1);
        load_byte(2, 8'h42, 1'b1, 1'b1);
        run_model();
        first_start_cycle = -1;
        raise_cycle       = cycle + 1;
        grant_fix    = 4'b0100;
        grant_fix_en = 1'b1;
        drain(400);
        grant_fix_en = 1'b0;
        check("first_latency", first_start_cycle - raise_cycle, 2);
        check("idle_after_pkt", state_dbg, IDLE);
        check("grant_idle", grant, 0);

        // contention right after reset: requester 0 before requester 3
        do_reset();
        load_packet(0, 1);
        load_packet(3, 1);
        run_model();
        drain(400);

        // fairness: everyone back-to-back single-byte packets
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < NUM_REQ; i++) load_packet(i, 1);
        run_model();
        drain(800);

        // packet hold: requester 0 waits for requester 1's whole packet
        load_packet(1, 3);
        run_model();
        step();
        wait_grant(4'b0010, 20);
        load_packet(0, 1);
        run_model();
        drain(800);

        // gap timeout: requester 1 stalls after a non-last byte
        timeout_seen = 0;
        load_byte(1, 8'h5a, 1'b0, 1'b0);
        exp_q.push_back({2'd1, 8'h5a});
        load_packet(0, 1);
        load_packet(2, 1);
        model_lo = 1;
        run_model();
        drain(800);
        check("timeout_count", timeout_seen, 1);

        // randomized rounds
        timeout_seen = 0;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    n = $urandom_range(1, 2);
                    for (int p = 0; p < n; p++) load_packet(i, $urandom_range(1, 4));
                end
            end
            run_model();
            drain(3000);
        end
        check("no_timeout", timeout_seen, 0);

        // reset while waiting for tx_done, then a spurious tx_done in IDLE
        load_packet(3, 3);
        run_model();
        s = n_tx_start;
        n = 0;
        while (n_tx_start == s && n < 50) begin
            step();
            n++;
        end
        check("start_before_reset", n_tx_start - s, 1);
        step();
        do_reset();
        spurious_done = 1'b1;
        s = n_tx_start;
        repeat (10) step();
        check("no_tx_after_reset", n_tx_start - s, 0);
        check("idle_after_reset", state_dbg, IDLE);
        check("grant_after_reset", grant, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
